// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read controller bus: FIFO read port plus the downstream valid/ready stream.
// The master modport is the controller, the slave modport is the FIFO/sink side.
interface fifo_rd_ctrl_if #(
  parameter int DATA_W = 128
);
  logic              o_fifo_rden;
  logic [DATA_W-1:0] i_fifo_rddata;
  logic              i_fifo_empty;
  logic              i_fifo_alm_empty;
  logic              i_flush;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              i_ready;
  logic              o_busy;

  modport master (
    output o_fifo_rden,
    input  i_fifo_rddata,
    input  i_fifo_empty,
    input  i_fifo_alm_empty,
    input  i_flush,
    output o_valid,
    output o_data,
    output o_last,
    input  i_ready,
    output o_busy
  );

  modport slave (
    input  o_fifo_rden,
    output i_fifo_rddata,
    output i_fifo_empty,
    output i_fifo_alm_empty,
    output i_flush,
    input  o_valid,
    input  o_data,
    input  o_last,
    output i_ready,
    input  o_busy
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains a FWFT FIFO as full bursts at 1 word/cycle, or as partial bursts
// (one word per two cycles) after a flush request or an idle timeout.
module fifo_rd_ctrl #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst,
  fifo_rd_ctrl_if.master bus
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    PARTIAL
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     to_q, to_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rden;
  logic              xfer;
  logic              last_beat;

  assign xfer      = valid_q & bus.i_ready;
  assign last_beat = (beat_q == BEAT_MAX);

  assign rden = !rst && !bus.i_fifo_empty
              && (state_q != IDLE) && !pend_q
              && (!valid_q || bus.i_ready);

  assign bus.o_fifo_rden = rden;
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_last      = last_q;
  assign bus.o_busy      = !rst && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    to_d    = to_q;
    valid_d = valid_q;
    last_d  = last_q;
    pend_d  = pend_q;
    data_d  = data_q;
    if (xfer) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.i_fifo_empty && !bus.i_fifo_alm_empty) begin
          state_d = BURST;
          beat_d  = '0;
          to_d    = '0;
        end else if (!bus.i_fifo_empty
                     && (bus.i_flush || to_q == TO_MAX)) begin
          state_d = PARTIAL;
          beat_d  = '0;
          to_d    = '0;
        end else if (!bus.i_fifo_empty) begin
          if (to_q != TO_MAX) to_d = to_q + 1'b1;
        end else begin
          to_d = '0;
        end
      end
      BURST: begin
        if (rden) begin
          data_d  = bus.i_fifo_rddata;
          valid_d = 1'b1;
          last_d  = last_beat;
          beat_d  = beat_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      PARTIAL: begin
        // the pending cycle lets the FIFO flags settle so o_last is exact
        if (pend_q) begin
          pend_d  = 1'b0;
          valid_d = 1'b1;
          last_d  = bus.i_fifo_empty || last_beat;
          beat_d  = beat_q + 1'b1;
          if (bus.i_fifo_empty || last_beat) state_d = IDLE;
        end else if (rden) begin
          data_d  = bus.i_fifo_rddata;
          valid_d = 1'b0;
          pend_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FWFT FIFO, directed scenarios,
// and a scoreboard monitor that checks every accepted output beat.
module tb_fifo_rd_ctrl;

  localparam int DW = 128;
  localparam int BL = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_rd_ctrl_if #(.DATA_W(DW)) bus ();

  fifo_rd_ctrl #(
    .DATA_W(DW),
    .BURST_LEN(BL),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          f_empty = 1'b1;
  logic          f_alm = 1'b1;
  logic [DW-1:0] f_head = '0;
  exp_t          mon_e;
  int            vectors = 0;
  int            miscompares = 0;

  assign bus.i_fifo_empty     = f_empty;
  assign bus.i_fifo_alm_empty = f_alm;
  assign bus.i_fifo_rddata    = f_head;

  // FWFT FIFO model, flags registered; almost-empty threshold = BL
  always @(posedge clk) begin
    if (bus.o_fifo_rden && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (wr_en) fifo_q.push_back(wr_data);
    f_empty <= (fifo_q.size() == 0);
    f_alm   <= (fifo_q.size() < BL);
    f_head  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  always @(negedge clk) begin
    if (bus.o_fifo_rden && bus.i_fifo_empty) begin
      miscompares++;
      $display("FAIL rden_on_empty at %0t: rden=1, required 0", $time);
    end
    if (!rst && bus.o_valid && bus.i_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat: got data=%h last=%b, required no beat",
                 bus.o_data, bus.o_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.o_data !== mon_e.data || bus.o_last !== mon_e.last) begin
          miscompares++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                   bus.o_data, bus.o_last, mon_e.data, mon_e.last);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] w(input logic [7:0] tag, input int i);
    return {tag, 88'h0, 32'(i)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({d, l});
  endtask

  task automatic write(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_word(input string name, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!(bus.o_valid && bus.o_data == d) && n < 60) begin
      step();
      n++;
    end
    check(name, {bus.o_valid, bus.o_data == d}, 2'b11);
  endtask

  initial begin
    logic [7:0] rd_pat;
    logic [7:0] vld_pat;
    logic [5:0] p_pat;
    int         k;
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b0;
    rst = 1'b1;

    // reset held while the FIFO fills with 5 words
    for (int i = 0; i < 5; i++) write(w(8'hA0, i));
    for (int i = 0; i < 2; i++) begin
      check("rst_quiet", {bus.o_fifo_rden, bus.o_valid, bus.o_busy}, 3'b000);
      step();
    end
    for (int i = 0; i < 4; i++) expect_beat(w(8'hA0, i), i == 3);
    expect_beat(w(8'hA0, 4), 1'b1);
    rst = 1'b0;
    rd_pat = '0;
    vld_pat = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      rd_pat  = {rd_pat[6:0], bus.o_fifo_rden};
      vld_pat = {vld_pat[6:0], bus.o_valid};
    end
    check("burst_rden", rd_pat, 8'b1111_0000);
    check("burst_valid", vld_pat, 8'b0111_1000);
    drain("drain_a");
    step();
    check("idle_after_a", bus.o_busy, 1'b0);

    // stall while S1 is presented
    for (int i = 0; i < 4; i++) expect_beat(w(8'h51, i), i == 3);
    for (int i = 0; i < 4; i++) write(w(8'h51, i));
    wait_word("stall_seen", w(8'h51, 1));
    bus.i_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_data", bus.o_data, w(8'h51, 1));
      check("stall_ctl", {bus.o_valid, bus.o_fifo_rden, bus.o_last}, 3'b100);
      if (i < 2) step();
    end
    bus.i_ready = 1'b1;
    drain("drain_stall");

    // two words, partial burst forced by timeout
    expect_beat(w(8'hB0, 0), 1'b0);
    expect_beat(w(8'hB0, 1), 1'b1);
    wr_en = 1'b1;
    wr_data = w(8'hB0, 0);
    step();
    k = 1;
    wr_data = w(8'hB0, 1);
    step();
    wr_en = 1'b0;
    k = 2;
    while (!bus.o_busy && k < 40) begin
      step();
      k++;
    end
    check("timeout_cycles", k, 17);
    p_pat = '0;
    for (int i = 0; i < 6; i++) begin
      p_pat = {p_pat[4:0], bus.o_valid};
      if (i < 5) step();
    end
    check("partial_spacing", p_pat, 6'b001010);
    drain("drain_b");
    check("idle_after_b", bus.o_busy, 1'b0);

    // single word flushed by a one-cycle pulse
    expect_beat(w(8'hC0, 0), 1'b1);
    write(w(8'hC0, 0));
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    check("flush_busy", bus.o_busy, 1'b1);
    drain("drain_c");
    step();
    check("idle_after_c", {bus.o_busy, bus.o_valid}, 2'b00);
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    step();
    check("flush_empty", {bus.o_busy, bus.o_fifo_rden}, 2'b00);

    // reset after two beats; D2 is lost, D3 rides in a fresh burst
    expect_beat(w(8'hD0, 0), 1'b0);
    expect_beat(w(8'hD0, 1), 1'b0);
    for (int i = 3; i < 7; i++) expect_beat(w(8'hD0, i), i == 6);
    for (int i = 0; i < 4; i++) write(w(8'hD0, i));
    wait_word("mid_d1", w(8'hD0, 1));
    step();
    check("mid_d2", bus.o_data, w(8'hD0, 2));
    rst = 1'b1;
    #1;
    check("mid_rst_rden", bus.o_fifo_rden, 1'b0);
    step();
    check("mid_rst_state", {bus.o_valid, bus.o_busy, bus.o_fifo_rden}, 3'b000);
    rst = 1'b0;
    for (int i = 4; i < 7; i++) write(w(8'hD0, i));
    drain("drain_d");
    step();
    check("idle_after_d", bus.o_busy, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning data width of FIFO words and output stream.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning beats per full burst; legal range is BURST_LEN >= 2.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning idle cycles with a partially filled FIFO before a partial burst is forced; legal range is TIMEOUT >= 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port o_fifo_rden, output, 1 bit: pop strobe to the FIFO read enable.
REQ-007 SHALL have port i_fifo_rddata, input, DATA_W bits: FIFO head word, first-word fall-through, valid while i_fifo_empty=0.
REQ-008 SHALL have port i_fifo_empty, input, 1 bit: FIFO empty flag.
REQ-009 SHALL have port i_fifo_alm_empty, input, 1 bit: FIFO almost-empty flag; the FIFO is configured with LOW_TH = BURST_LEN, so 0 means at least BURST_LEN words are stored.
REQ-010 SHALL have port i_flush, input, 1 bit: request to send the remaining words as a partial burst.
REQ-011 SHALL have port o_valid, output, 1 bit: output word valid.
REQ-012 SHALL have port o_data, output, DATA_W bits: output word.
REQ-013 SHALL have port o_last, output, 1 bit: marks the final beat of a burst; qualified by o_valid.
REQ-014 SHALL have port i_ready, input, 1 bit: downstream accept; a transfer occurs when o_valid=1 and i_ready=1.
REQ-015 SHALL have port o_busy, output, 1 bit: 1 whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, BURST and PARTIAL, with a beat counter of $clog2(BURST_LEN) bits and a saturating timeout counter.
REQ-017 SHALL drive o_fifo_rden combinationally as: rst=0 AND i_fifo_empty=0 AND state is BURST or PARTIAL AND pending=0 AND (o_valid=0 OR i_ready=1).
REQ-018 SHALL transition IDLE->BURST when i_fifo_empty=0 and i_fifo_alm_empty=0; this takes priority over the PARTIAL entry conditions, and the beat counter is cleared on entry.
REQ-019 SHALL transition IDLE->PARTIAL when i_fifo_empty=0, i_fifo_alm_empty=1, and either i_flush=1 or the timeout counter equals TIMEOUT-1; the beat counter is cleared on entry.
REQ-020 SHALL, in IDLE, increment the timeout counter each cycle with i_fifo_empty=0 and clear it when i_fifo_empty=1 or on leaving IDLE; i_flush with an empty FIFO has no effect.
REQ-021 SHALL, in BURST, load each popped word into o_data with o_valid=1 on the edge after the pop, so read-to-output latency is 1 cycle and throughput is 1 word/cycle.
REQ-022 SHALL, in BURST, set o_last=1 for the pop taken at beat==BURST_LEN-1 and return to IDLE on that edge.
REQ-023 SHALL, in PARTIAL, load each popped word into o_data with o_valid=0 and pending=1.
REQ-024 SHALL, on the following edge, set pending=0 and o_valid=1 with o_last = i_fifo_empty OR (beat==BURST_LEN-1), increment beat, and go to IDLE if o_last=1, giving at most 1 word per 2 cycles.
REQ-025 SHALL hold o_data and o_last stable while o_valid=1 and i_ready=0.
REQ-026 SHALL clear o_valid on a transfer unless a new word is loaded on the same edge.
REQ-027 SHALL allow the IDLE->BURST decision while the previous last beat is still stalled; no pop occurs until that beat transfers.
REQ-028 SHALL never drop, duplicate or reorder words, and SHALL never assert o_fifo_rden while i_fifo_empty=1.
REQ-029 SHALL treat an upstream write in the same cycle as a PARTIAL pop as making the FIFO non-empty at the pending cycle, so o_last=0 and the next word is guaranteed present.

Reset
REQ-030 SHALL, when rst=1 at an edge, set state=IDLE, o_valid=0, o_last=0, o_data=0, pending=0, beat counter=0 and timeout counter=0.
REQ-031 SHALL hold o_fifo_rden=0 and o_busy=0 while rst=1.
REQ-032 SHALL discard an in-flight burst on reset mid-operation, with no recovery of that burst.

Verification
REQ-033 SHALL cover: rst=1 for 2 cycles with FIFO holding 5 words -> o_fifo_rden=0, o_valid=0, o_busy=0 throughout.
REQ-034 SHALL cover: FIFO holds A0..A3, i_ready=1 -> BURST next cycle, o_fifo_rden high 4 consecutive cycles, o_valid with A0..A3 1 cycle later, o_last=1 only on A3.
REQ-035 SHALL cover: full burst with i_ready=0 for 3 cycles while A1 is presented -> o_data=A1 stable, o_fifo_rden=0, then A2 and A3 follow with no loss.
REQ-036 SHALL cover: FIFO holds B0,B1, i_flush=0, TIMEOUT=16 -> PARTIAL after 16 non-empty IDLE cycles, B0 with o_last=0 and B1 with o_last=1, each 2 cycles apart.
REQ-037 SHALL cover: FIFO holds C0, 1-cycle i_flush pulse -> single beat C0 with o_last=1, then IDLE with o_busy=0.
REQ-038 SHALL cover: rst=1 after 2 beats of a full burst -> next edge o_valid=0, state IDLE, no pops during reset, remaining words sent as a fresh burst once 4 words are available.
